// File: rtl/prompt_scheduler.sv
`timescale 1ns/1ps
// prompt_scheduler: NotNot round controller. It drives the shared XNOR LFSR,
// presents one prompt per round, judges responses against a tick deadline and keeps score.
module prompt_scheduler #(
  parameter int ROUND_TICKS = 2000,
  parameter int GAP_TICKS   = 500,
  parameter int MAX_ROUNDS  = 32,
  parameter int LIVES       = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       tick,
  input  logic       resp_valid,
  input  logic [1:0] resp_dir,
  input  logic [2:0] lfsr_value,
  output logic       lfsr_enable,
  output logic       lfsr_reset,
  output logic [2:0] lfsr_seed,
  output logic       prompt_valid,
  output logic [1:0] prompt_dir,
  output logic       prompt_not,
  output logic       result_valid,
  output logic       result_correct,
  output logic [7:0] score,
  output logic [3:0] lives_left,
  output logic [7:0] round_count,
  output logic       game_over
);

  localparam int SPAN    = (ROUND_TICKS > GAP_TICKS) ? ROUND_TICKS : GAP_TICKS;
  localparam int TIMER_W = $clog2(SPAN) + 1;
  localparam logic [TIMER_W-1:0] ROUND_LAST = TIMER_W'(ROUND_TICKS - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST   = TIMER_W'(GAP_TICKS - 1);
  localparam logic [3:0] LIVES_INIT = 4'(LIVES);
  localparam logic [7:0] ROUNDS_END = 8'(MAX_ROUNDS);

  typedef enum logic [2:0] {IDLE, SEED, STEP, LATCH, PROMPT, GAP, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [2:0]         seed_cnt;
  logic [2:0]         seed_hold;
  logic [TIMER_W-1:0] timer;
  logic               start_game;
  logic               timeout;
  logic               gap_end;
  logic               judge;
  logic               resp_match;
  logic               correct;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] floor_dec4(input logic [3:0] v);
    return (v == 4'd0) ? v : v - 4'd1;
  endfunction

  assign start_game = start && ((state == IDLE) || (state == DONE));
  assign timeout    = tick && (timer == ROUND_LAST);
  assign gap_end    = tick && (timer == GAP_LAST);
  assign resp_match = (resp_dir == prompt_dir);
  // A response arriving on the deadline tick still counts, so correctness keys off resp_valid only.
  assign correct    = resp_valid && (prompt_not ? !resp_match : resp_match);
  assign judge      = (state == PROMPT) && (resp_valid || timeout);
  assign lfsr_seed  = seed_hold;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    lfsr_enable  = 1'b0;
    lfsr_reset   = 1'b0;
    prompt_valid = 1'b0;
    game_over    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SEED;
      end
      SEED: begin
        lfsr_enable = 1'b1;
        lfsr_reset  = 1'b1;
        state_next  = STEP;
      end
      STEP: begin
        lfsr_enable = 1'b1;
        state_next  = LATCH;
      end
      LATCH: begin
        state_next = PROMPT;
      end
      PROMPT: begin
        prompt_valid = 1'b1;
        if (resp_valid || timeout) state_next = GAP;
      end
      GAP: begin
        if (gap_end) begin
          state_next = ((lives_left == 4'd0) || (round_count == ROUNDS_END)) ? DONE : STEP;
        end
      end
      DONE: begin
        game_over = 1'b1;
        if (start) state_next = SEED;
      end
      default: state_next = IDLE;
    endcase
  end

  // seed_cnt skips 111, the XNOR lock-up value, so any start yields a live seed.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      seed_cnt       <= 3'd0;
      seed_hold      <= 3'd0;
      timer          <= '0;
      prompt_dir     <= 2'd0;
      prompt_not     <= 1'b0;
      result_valid   <= 1'b0;
      result_correct <= 1'b0;
      score          <= 8'd0;
      lives_left     <= LIVES_INIT;
      round_count    <= 8'd0;
    end else begin
      seed_cnt       <= (seed_cnt == 3'd6) ? 3'd0 : seed_cnt + 3'd1;
      result_valid   <= judge;
      result_correct <= judge && correct;

      if (start_game) begin
        seed_hold   <= seed_cnt;
        score       <= 8'd0;
        lives_left  <= LIVES_INIT;
        round_count <= 8'd0;
      end

      if (state == LATCH) begin
        prompt_dir <= lfsr_value[1:0];
        prompt_not <= lfsr_value[2];
        timer      <= '0;
      end else if (judge) begin
        timer <= '0;
      end else if (((state == PROMPT) || (state == GAP)) && tick) begin
        timer <= timer + 1'b1;
      end

      if (judge) begin
        if (correct) begin
          score <= sat_inc8(score);
        end else begin
          lives_left <= floor_dec4(lives_left);
        end
        round_count <= round_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_prompt_scheduler.sv
`timescale 1ns/1ps
// Bench for prompt_scheduler: a stand-in XNOR LFSR, a game-level reference model feeding
// an expected-result queue, and a monitor that checks every result pulse against it.
module tb_prompt_scheduler;
  localparam int ROUND_TICKS = 4;
  localparam int GAP_TICKS   = 2;
  localparam int MAX_ROUNDS  = 4;
  localparam int LIVES       = 3;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic       resp_valid = 1'b0;
  logic [1:0] resp_dir = 2'd0;
  logic [2:0] lfsr_value;
  logic       lfsr_enable, lfsr_reset;
  logic [2:0] lfsr_seed;
  logic       prompt_valid, prompt_not, result_valid, result_correct, game_over;
  logic [1:0] prompt_dir;
  logic [7:0] score, round_count;
  logic [3:0] lives_left;

  prompt_scheduler #(
    .ROUND_TICKS(ROUND_TICKS), .GAP_TICKS(GAP_TICKS),
    .MAX_ROUNDS(MAX_ROUNDS), .LIVES(LIVES)
  ) dut (
    .clock(clock), .resetn(resetn), .start(start), .tick(tick),
    .resp_valid(resp_valid), .resp_dir(resp_dir), .lfsr_value(lfsr_value),
    .lfsr_enable(lfsr_enable), .lfsr_reset(lfsr_reset), .lfsr_seed(lfsr_seed),
    .prompt_valid(prompt_valid), .prompt_dir(prompt_dir), .prompt_not(prompt_not),
    .result_valid(result_valid), .result_correct(result_correct), .score(score),
    .lives_left(lives_left), .round_count(round_count), .game_over(game_over)
  );

  always #5 clock = ~clock;

  function automatic logic [2:0] lfsr_next(input logic [2:0] s);
    return {s[1:0], ~(s[2] ^ s[1])};
  endfunction

  // Stand-in for the external 3-bit XNOR LFSR (no reset pin of its own).
  logic [2:0] lfsr_q = 3'b000;
  always @(posedge clock) begin
    if (lfsr_enable) lfsr_q <= lfsr_reset ? lfsr_seed : lfsr_next(lfsr_q);
  end
  assign lfsr_value = lfsr_q;

  // Model of the free-running seed counter: clocks since reset, modulo 7.
  int m_seed_cnt;
  always @(posedge clock or negedge resetn) begin
    if (!resetn) m_seed_cnt <= 0;
    else m_seed_cnt <= (m_seed_cnt + 1) % 7;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       correct;
    int         score;
    int         lives;
    int         rounds;
    logic [1:0] pdir;
    logic       pnot;
  } exp_t;
  exp_t exp_q[$];

  logic [2:0] m_lfsr;
  int m_score, m_lives, m_rounds;

  function automatic bit m_over();
    return (m_lives == 0) || (m_rounds == MAX_ROUNDS);
  endfunction

  function automatic logic [1:0] pick_dir(input logic [2:0] p, input bit good);
    if (p[2]) return good ? p[1:0] + 2'd1 : p[1:0];
    return good ? p[1:0] : p[1:0] + 2'd1;
  endfunction

  always @(negedge clock) begin
    if (resetn && result_valid) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("result_correct", result_correct, e.correct);
        check("score", score, e.score);
        check("lives_left", lives_left, e.lives);
        check("round_count", round_count, e.rounds);
        check("result_prompt_dir", prompt_dir, e.pdir);
        check("result_prompt_not", prompt_not, e.pnot);
      end
    end
  end

  task automatic begin_game(input int want_seed);
    int guard;
    logic [2:0] game_seed;
    guard = 0;
    if (want_seed >= 0) begin
      while ((m_seed_cnt != want_seed) && (guard < 20)) begin
        @(negedge clock);
        guard++;
      end
    end
    game_seed = 3'(m_seed_cnt);
    start = 1'b1;
    m_lfsr = game_seed;
    m_score = 0;
    m_lives = LIVES;
    m_rounds = 0;
    @(negedge clock);
    start = 1'b0;
    check("seed_lfsr_reset", lfsr_reset, 1);
    check("seed_lfsr_enable", lfsr_enable, 1);
    check("seed_value", lfsr_seed, game_seed);
    check("start_game_over", game_over, 0);
    check("start_score", score, 0);
    check("start_lives", lives_left, LIVES);
    check("start_rounds", round_count, 0);
  endtask

  // mode 0: respond after pre_ticks ticks; 1: let it time out; 2: respond on the deadline tick
  task automatic play_round(input int mode, input logic [1:0] dir, input int pre_ticks);
    exp_t e;
    int guard;
    int n;
    bit ok;
    guard = 0;
    while (!prompt_valid && (guard < 20)) begin
      @(negedge clock);
      guard++;
    end
    check("prompt_valid_wait", prompt_valid, 1);
    m_lfsr = lfsr_next(m_lfsr);
    check("prompt_dir", prompt_dir, m_lfsr[1:0]);
    check("prompt_not", prompt_not, m_lfsr[2]);
    ok = (mode != 1) && (m_lfsr[2] ? (dir != m_lfsr[1:0]) : (dir == m_lfsr[1:0]));
    m_rounds++;
    if (ok) m_score = (m_score == 255) ? 255 : m_score + 1;
    else m_lives--;
    e.correct = ok;
    e.score = m_score;
    e.lives = m_lives;
    e.rounds = m_rounds;
    e.pdir = m_lfsr[1:0];
    e.pnot = m_lfsr[2];
    exp_q.push_back(e);

    n = (mode == 0) ? pre_ticks : ROUND_TICKS - 1;
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clock);
      tick = 1'b0;
      @(negedge clock);
    end
    tick = (mode != 0);
    resp_valid = (mode != 1);
    resp_dir = dir;
    @(negedge clock);
    tick = 1'b0;
    resp_valid = 1'b0;
    check("prompt_closed", prompt_valid, 0);

    for (int g = 0; g < GAP_TICKS; g++) begin
      resp_valid = 1'($urandom_range(0, 1));
      resp_dir = 2'($urandom_range(0, 3));
      start = 1'($urandom_range(0, 1));
      @(negedge clock);
      resp_valid = 1'b0;
      start = 1'b0;
      tick = 1'b1;
      @(negedge clock);
      tick = 1'b0;
    end

    check("game_over_flag", game_over, m_over());
    if (m_over()) begin
      check("final_score", score, m_score);
      check("final_lives", lives_left, m_lives);
      check("final_rounds", round_count, m_rounds);
    end
  endtask

  // policy 0: random; 1: every round times out; 2: every round answered correctly
  task automatic play_game(input int policy);
    int r;
    int mode;
    logic [1:0] d;
    r = 0;
    begin_game(-1);
    while (!m_over() && (r < MAX_ROUNDS + 1)) begin
      case (policy)
        1: begin mode = 1; d = 2'd0; end
        2: begin
          mode = (r % 2 == 0) ? 0 : 2;
          d = pick_dir(lfsr_next(m_lfsr), 1'b1);
        end
        default: begin
          mode = $urandom_range(0, 2);
          d = 2'($urandom_range(0, 3));
        end
      endcase
      play_round(mode, d, $urandom_range(0, ROUND_TICKS - 2));
      r++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    repeat (2) @(negedge clock);
    check("rst_prompt_valid", prompt_valid, 0);
    check("rst_score", score, 0);
    check("rst_lives", lives_left, LIVES);
    check("rst_rounds", round_count, 0);
    check("rst_game_over", game_over, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_lfsr_enable", lfsr_enable, 0);
    check("rst_lfsr_seed", lfsr_seed, 0);
    resetn = 1'b1;
    @(negedge clock);

    // Seed 3: prompts run 110, 101, 010.
    begin_game(3);
    play_round(0, 2'b11, 1);
    check("seed3_round1_dir", prompt_dir, 2);
    check("seed3_round1_not", prompt_not, 1);
    check("seed3_round1_score", score, 1);
    play_round(0, 2'b01, 0);
    check("seed3_round2_dir", prompt_dir, 1);
    check("seed3_round2_not", prompt_not, 1);
    check("seed3_round2_lives", lives_left, 2);
    play_round(0, 2'b10, 2);
    check("seed3_round3_dir", prompt_dir, 2);
    check("seed3_round3_not", prompt_not, 0);
    check("seed3_round3_score", score, 2);

    // Reset while a prompt is open.
    guard = 0;
    while (!prompt_valid && (guard < 20)) begin
      @(negedge clock);
      guard++;
    end
    check("midgame_prompt_open", prompt_valid, 1);
    resetn = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("midrst_prompt_valid", prompt_valid, 0);
    check("midrst_score", score, 0);
    check("midrst_lives", lives_left, LIVES);
    check("midrst_rounds", round_count, 0);
    check("midrst_game_over", game_over, 0);
    check("midrst_lfsr_enable", lfsr_enable, 0);
    resetn = 1'b1;
    @(negedge clock);

    play_game(1);
    check("timeouts_rounds", round_count, LIVES);
    check("timeouts_over", game_over, 1);
    play_game(2);
    check("allgood_score", score, MAX_ROUNDS);
    check("allgood_lives", lives_left, LIVES);
    for (int g = 0; g < 10; g++) play_game(0);

    repeat (4) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prompt_scheduler.md
# prompt_scheduler

Round controller for the NotNot game: sequences the shared 3-bit XNOR LFSR (lfsr_3bits) to generate one random prompt per round, presents it to the display/input logic, judges the player's response against a tick-based deadline, and tracks score, lives and round count. It sits between the button/timebase logic and the LFSR instance and owns the LFSR's enable, reset and seed pins exclusively.

## Interface
- ROUND_TICKS, 2000: ticks allowed for a response (≥2)
- GAP_TICKS, 500: ticks of dead time between rounds (≥1)
- MAX_ROUNDS, 32: rounds per game (1..255)
- LIVES, 3: wrong answers allowed before game over (1..15)

- clock  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  level; sampled only in IDLE or DONE
- tick  in  1  one-cycle timebase pulse (e.g. 1 ms)
- resp_valid  in  1  one-cycle player response strobe
- resp_dir  in  2  response direction (00 up, 01 right, 10 down, 11 left)
- lfsr_value  in  3  LFSR lfsr_out
- lfsr_enable  out  1  to LFSR enable
- lfsr_reset  out  1  to LFSR reset (load seed)
- lfsr_seed  out  3  to LFSR seed
- prompt_valid  out  1  prompt on display, response window open
- prompt_dir  out  2  prompt direction
- prompt_not  out  1  1 = "NOT" prompt
- result_valid  out  1  one-cycle pulse per judged round
- result_correct  out  1  valid with result_valid
- score  out  8  correct answers, saturates at 255
- lives_left  out  4  remaining lives
- round_count  out  8  rounds judged this game
- game_over  out  1  high in DONE

## Operation
- States: IDLE, SEED, STEP, LATCH, PROMPT, GAP, DONE.
- seed_cnt: free-running 3-bit, 0..6 then wraps to 0, every clock in every state; never 111 (XNOR lock-up value).
- IDLE/DONE + start=1 → SEED; clear score, round_count; lives_left=LIVES; game_over=0.
- SEED (1 cycle): lfsr_enable=1, lfsr_reset=1, lfsr_seed=seed_cnt (value latched on entry, held constant) → STEP.
- STEP (1 cycle): lfsr_enable=1, lfsr_reset=0 → LATCH.
- LATCH (1 cycle): prompt_dir<=lfsr_value[1:0], prompt_not<=lfsr_value[2], clear tick timer → PROMPT.
- lfsr_enable=0 in all other states; LFSR holds its value.
- PROMPT: prompt_valid=1. Correct iff (prompt_not=0 and resp_dir==prompt_dir) or (prompt_not=1 and resp_dir!=prompt_dir).
  - resp_valid=1 → judge, → GAP.
  - else tick=1 with timer==ROUND_TICKS-1 → timeout, judged wrong, → GAP.
  - resp_valid and timeout in same cycle: response wins.
- Judging (on the PROMPT exit edge): result_valid=1 for one cycle; correct → score+1 (saturate); wrong → lives_left-1; round_count+1.
- GAP: prompt_valid=0; responses ignored; after GAP_TICKS ticks: lives_left==0 or round_count==MAX_ROUNDS → DONE, else STEP (no reseed).
- DONE: game_over=1; score/lives_left/round_count held until next start.
- resp_valid outside PROMPT, start outside IDLE/DONE: ignored.

## Timing
- Reset (async, any state): IDLE; all outputs 0 except lives_left=LIVES; seed_cnt=0. LFSR not reset (no reset pin); reseeded at next game start.
- start sampled at edge E0 → SEED; LFSR loads seed at E1; shifts at E2; prompt_valid=1 after E3.
- Later rounds: GAP exit edge → prompt_valid=1 two edges later.
- Response sampled at edge E → prompt_valid=0, result_valid=1, counters updated after E; result_valid low after E+1.
- Timeout: judged on the edge sampling the ROUND_TICKS-th tick of PROMPT.
- LFSR's internal reload on value 111 needs no controller action.

## Test plan
- Reset mid-PROMPT (resetn=0 for 2 cycles) → prompt_valid=0, score=0, lives_left=3, state IDLE; next start re-enters SEED.
- start when seed_cnt=3 → SEED drives lfsr_seed=011, lfsr_reset=1; first prompt 110 (dir=10, not=1); second round prompt 101 (dir=01, not=1).
- prompt dir=10, not=0, resp_dir=10 → result_correct=1, score 0→1; resp_dir=01 → result_correct=0, lives_left 3→2.
- prompt not=1, dir=01: resp_dir=01 → wrong; resp_dir=11 → correct.
- ROUND_TICKS=4, no response → result_valid on 4th tick, wrong; resp_valid on that same cycle with correct dir → correct, no life lost.
- LIVES=3, three wrong answers → game_over=1 after third GAP, round_count=3; MAX_ROUNDS=2 all correct → DONE with score=2, lives_left=3; start in DONE → fresh game.
